// File: rtl/expr_misr_pkg.sv
// Shared definitions for the expression-result MISR: FSM states, default
// polynomial/seed constants and the fold/step functions used by RTL and benches.
package expr_misr_pkg;

   localparam int          Y_W      = 90;
   localparam int          SIG_W    = 32;
   localparam int          CNT_W    = 16;
   localparam logic [31:0] POLY_DEF = 32'h04C11DB7;
   localparam logic [31:0] SEED_DEF = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Compress the 90-bit result into 32 bits; the top chunk is zero-extended.
   function automatic logic [31:0] fold(input logic [89:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b000000, y[89:64]};
   endfunction

   // One Galois MISR shift with feedback, then absorb the folded chunk.
   function automatic logic [31:0] step(input logic [31:0] m,
                                        input logic [31:0] c,
                                        input logic [31:0] poly);
      return {m[30:0], 1'b0} ^ (m[31] ? poly : 32'h00000000) ^ c;
   endfunction

endpackage

// File: rtl/expr_misr_step.sv
// Combinational next-state of the MISR for one accepted result vector.
module expr_misr_step
   import expr_misr_pkg::*;
#(
   parameter logic [31:0] POLY = POLY_DEF
) (
   input  logic [31:0] misr_q,
   input  logic [89:0] y,
   output logic [31:0] misr_d
);

   logic [31:0] chunk_s;

   // Fold then shift/absorb in a single combinational stage.
   always_comb begin
      chunk_s = fold(y);
      misr_d  = step(misr_q, chunk_s, POLY);
   end

endmodule

// File: rtl/expr_result_misr.sv
// Capture stage: compacts num_vec handshaked result vectors into a MISR
// signature and offers it on a second valid/ready handshake.
module expr_result_misr
   import expr_misr_pkg::*;
#(
   parameter int          Y_W   = 90,
   parameter int          SIG_W = 32,
   parameter int          CNT_W = 16,
   parameter logic [31:0] POLY  = POLY_DEF,
   parameter logic [31:0] SEED  = SEED_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Y_W-1:0]   in_y,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count,
   output logic             busy
);

   state_t           state_r;
   state_t           next_s;
   logic [CNT_W-1:0] target_r;
   logic [CNT_W-1:0] cnt_r;
   logic [SIG_W-1:0] misr_r;
   logic [SIG_W-1:0] misr_d_s;
   logic             in_ready_r;
   logic             sig_valid_r;
   logic             busy_r;
   logic             accept_s;
   logic             last_s;

   expr_misr_step #(.POLY(POLY)) u_step (
      .misr_q (misr_r),
      .y      (in_y),
      .misr_d (misr_d_s)
   );

   // in_ready_r mirrors state RUN, so accept never depends combinationally on in_valid for ready.
   always_comb begin
      accept_s = in_valid & in_ready_r;
      last_s   = (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == target_r;
   end

   // Next-state decode for IDLE/RUN/DONE.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = (num_vec != {CNT_W{1'b0}}) ? RUN : DONE;
            end else begin
               next_s = IDLE;
            end
         end
         RUN: begin
            if (accept_s && last_s) begin
               next_s = DONE;
            end else begin
               next_s = RUN;
            end
         end
         DONE: begin
            if (sig_valid_r && sig_ready) begin
               next_s = IDLE;
            end else begin
               next_s = DONE;
            end
         end
         default: next_s = IDLE;
      endcase
   end

   // State register and registered handshake flags derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         sig_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= next_s;
         in_ready_r  <= (next_s == RUN);
         sig_valid_r <= (next_s == DONE);
         busy_r      <= (next_s != IDLE);
      end
   end

   // Datapath: seed on start, absorb on accept, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         target_r <= {CNT_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         misr_r   <= {SIG_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  target_r <= num_vec;
                  cnt_r    <= {CNT_W{1'b0}};
                  misr_r   <= SEED;
               end
            end
            RUN: begin
               if (accept_s) begin
                  cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  misr_r <= misr_d_s;
               end
            end
            DONE: begin
               misr_r <= misr_r;
            end
            default: begin
               misr_r <= misr_r;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign sig_valid = sig_valid_r;
   assign busy      = busy_r;
   assign signature = misr_r;
   assign vec_count = cnt_r;

endmodule

// File: tb/tb_expr_result_misr.sv
// Self-checking bench for expr_result_misr: fixed vector table, hand-written
// corner sequences and randomized runs against an arithmetic reference model.
module tb_expr_result_misr;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_vec;
   logic        in_valid;
   logic        in_ready;
   logic [89:0] in_y;
   logic        sig_valid;
   logic        sig_ready;
   logic [31:0] signature;
   logic [15:0] vec_count;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   logic [89:0] vq[$];

   typedef struct {
      int          n;
      logic [89:0] y;
      logic [31:0] sig;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[4];

   expr_result_misr dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_vec   (num_vec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_y      (in_y),
      .sig_valid (sig_valid),
      .sig_ready (sig_ready),
      .signature (signature),
      .vec_count (vec_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: CRC-style polynomial arithmetic over the queued vectors.
   function automatic logic [31:0] model_sig(input int n);
      longint unsigned m;
      longint unsigned c;
      longint unsigned chunk;
      m = 64'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = 0;
         for (int k = 0; k < 3; k++) begin
            chunk = 64'((vq[i] >> (32 * k)) & 90'hFFFFFFFF);
            c = c ^ chunk;
         end
         m = m * 2;
         if (m >= 64'h100000000) m = (m - 64'h100000000) ^ 64'h04C11DB7;
         m = m ^ c;
      end
      return m[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full run over vq[0..n-1]; returns the offered signature and count.
   task automatic do_run(input int n, input bit bubbles, output logic [31:0] sig, output logic [15:0] cnt);
      int t;
      start   = 1'b1;
      num_vec = 16'(n);
      tick();
      start = 1'b0;
      if (n == 0) begin
         chk("zero_in_ready", 64'(in_ready), 64'd0);
         chk("zero_sig_valid", 64'(sig_valid), 64'd1);
      end else begin
         chk("run_in_ready", 64'(in_ready), 64'd1);
      end
      for (int i = 0; i < n; i++) begin
         if (bubbles) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         in_valid = 1'b1;
         in_y     = vq[i];
         t = 0;
         while (!in_ready && t < 20) begin
            tick();
            t++;
         end
         if (t >= 20) chk("in_ready_timeout", 64'd0, 64'd1);
         tick();
         in_valid = 1'b0;
      end
      if (n > 0) chk("sig_latency", 64'(sig_valid), 64'd1);
      t = 0;
      while (!sig_valid && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) chk("sig_valid_timeout", 64'd0, 64'd1);
      sig = signature;
      cnt = vec_count;
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      chk("sig_drop", 64'(sig_valid), 64'd0);
      chk("sig_keep", 64'(signature), 64'(sig));
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [31:0] s1, s2;
      logic [15:0] c1, c2;
      logic [89:0] yr;
      int          n;

      rst = 1'b1; start = 1'b0; num_vec = 16'd0; in_valid = 1'b0;
      in_y = 90'd0; sig_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_sig_valid", 64'(sig_valid), 64'd0);
      chk("rst_signature", 64'(signature), 64'd0);
      chk("rst_vec_count", 64'(vec_count), 64'd0);

      tbl[0] = '{n: 1, y: 90'd0, sig: 32'hFB3EE249, cnt: 16'd1};
      tbl[1] = '{n: 1, y: 90'd1, sig: 32'hFB3EE248, cnt: 16'd1};
      tbl[2] = '{n: 0, y: 90'd0, sig: 32'hFFFFFFFF, cnt: 16'd0};
      tbl[3] = '{n: 2, y: 90'd0, sig: 32'hF2BCD925, cnt: 16'd2};
      for (int r = 0; r < 4; r++) begin
         vq.delete();
         for (int i = 0; i < tbl[r].n; i++) vq.push_back(tbl[r].y);
         do_run(tbl[r].n, 1'b0, s1, c1);
         chk($sformatf("tbl%0d_sig", r), 64'(s1), 64'(tbl[r].sig));
         chk($sformatf("tbl%0d_cnt", r), 64'(c1), 64'(tbl[r].cnt));
      end

      // Four vectors back-to-back vs. with bubbles.
      vq.delete();
      for (int i = 0; i < 4; i++) begin
         yr[31:0] = $urandom(); yr[63:32] = $urandom(); yr[89:64] = 26'($urandom());
         vq.push_back(yr);
      end
      do_run(4, 1'b0, s1, c1);
      do_run(4, 1'b1, s2, c2);
      chk("b2b_sig", 64'(s1), 64'(model_sig(4)));
      chk("bubble_sig", 64'(s2), 64'(model_sig(4)));
      chk("bubble_cnt", 64'(c2), 64'd4);

      // Signature held under back-pressure; start ignored in DONE.
      start = 1'b1; num_vec = 16'd1; tick(); start = 1'b0;
      in_valid = 1'b1; in_y = vq[0]; tick(); in_valid = 1'b0;
      s1 = signature;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            start = 1'b1; num_vec = 16'd7;
         end else begin
            start = 1'b0;
         end
         chk("hold_sig_valid", 64'(sig_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_sig", 64'(signature), 64'(model_sig(1)));
         chk("hold_cnt", 64'(vec_count), 64'd1);
         tick();
      end
      start = 1'b0;
      sig_ready = 1'b1; tick(); sig_ready = 1'b0;
      chk("hold_release", 64'(sig_valid), 64'd0);
      tick();
      chk("hold_start_ignored", 64'(busy), 64'd0);

      // Reset in the middle of an 8-vector run.
      vq.delete();
      for (int i = 0; i < 8; i++) begin
         yr[31:0] = $urandom(); yr[63:32] = $urandom(); yr[89:64] = 26'($urandom());
         vq.push_back(yr);
      end
      start = 1'b1; num_vec = 16'd8; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_y = vq[i]; tick();
      end
      in_valid = 1'b0;
      chk("mid_cnt", 64'(vec_count), 64'd3);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_cnt", 64'(vec_count), 64'd0);
      chk("mid_rst_sig", 64'(signature), 64'd0);
      do_run(8, 1'b0, s1, c1);
      chk("fresh_sig", 64'(s1), 64'(model_sig(8)));
      chk("fresh_cnt", 64'(c1), 64'd8);

      // Randomized runs.
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(0, 9);
         vq.delete();
         for (int i = 0; i < n; i++) begin
            yr[31:0] = $urandom(); yr[63:32] = $urandom(); yr[89:64] = 26'($urandom());
            vq.push_back(yr);
         end
         do_run(n, 1'($urandom_range(0, 1)), s1, c1);
         chk($sformatf("rand%0d_sig", r), 64'(s1), 64'(model_sig(n)));
         chk($sformatf("rand%0d_cnt", r), 64'(c1), 64'(n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
